// File: rtl/sti_loader.sv
// sti_loader: receives one binary image serially, one pixel per handshake,
// packs the pixels 16 to a word (first pixel in bit 15) and writes each word
// into the sti memory. load_done holds once the frame is stored.
module sti_loader #(
  parameter int N_WORDS = 1024,
  parameter int WORD_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pix_valid,
  input  logic              pix_in,
  input  logic              pix_last,
  output logic              pix_ready,
  output logic              sti_wr,
  output logic [9:0]        sti_addr,
  output logic [WORD_W-1:0] sti_do,
  output logic              busy,
  output logic              load_done,
  output logic              frame_err
);

  localparam int              CW        = $clog2(WORD_W);
  localparam logic [9:0]      LAST_ADDR = 10'(N_WORDS - 1);
  localparam logic [CW-1:0]   LAST_BIT  = CW'(WORD_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  state_t              state_q;
  logic [CW-1:0]       bit_cnt_q;
  logic [9:0]          word_addr_q;
  logic [WORD_W-1:0]   shreg_q;
  logic                sti_wr_q;
  logic [9:0]          sti_addr_q;
  logic [WORD_W-1:0]   sti_do_q;
  logic                frame_err_q;

  logic [WORD_W-1:0]   word_d;
  logic [CW-1:0]       bit_idx;
  logic                accept;
  logic                word_full;
  logic                frame_end;

  // Current word with the incoming pixel merged in at its MSB-first slot.
  always_comb begin
    bit_idx         = LAST_BIT - bit_cnt_q;
    word_d          = shreg_q;
    word_d[bit_idx] = pix_in;
  end

  assign accept    = pix_valid && (state_q == S_LOAD);
  assign word_full = (bit_cnt_q == LAST_BIT);
  // The end-of-frame test is made before word_addr increments, so the
  // address never wraps inside a frame.
  assign frame_end = word_full && (word_addr_q == LAST_ADDR);

  // Loader FSM: packing, write strobe generation and frame-end bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      word_addr_q <= '0;
      shreg_q     <= '0;
      sti_wr_q    <= 1'b0;
      sti_addr_q  <= '0;
      sti_do_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sti_wr_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_LOAD;
            bit_cnt_q   <= '0;
            word_addr_q <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (frame_end || pix_last) begin
              // Final (possibly partial) word; unfilled low bits stay 0.
              sti_wr_q    <= 1'b1;
              sti_addr_q  <= word_addr_q;
              sti_do_q    <= word_d;
              frame_err_q <= !(frame_end && pix_last);
              shreg_q     <= '0;
              bit_cnt_q   <= '0;
              state_q     <= S_FLUSH;
            end else if (word_full) begin
              sti_wr_q    <= 1'b1;
              sti_addr_q  <= word_addr_q;
              sti_do_q    <= word_d;
              word_addr_q <= word_addr_q + 10'd1;
              shreg_q     <= '0;
              bit_cnt_q   <= '0;
            end else begin
              shreg_q   <= word_d;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        S_FLUSH: state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pix_ready = (state_q == S_LOAD);
  assign busy      = (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign load_done = (state_q == S_DONE);
  assign sti_wr    = sti_wr_q;
  assign sti_addr  = sti_addr_q;
  assign sti_do    = sti_do_q;
  assign frame_err = frame_err_q;

endmodule
